// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared definitions for the instruction fetch unit.
//   PC_W / INSTR_W   : word-address and instruction widths
//   RESET_PC_DEFAULT : default word address of the first fetch (byte 0x00003034)
//   fetch_state_e    : fetch control FSM states
//   pc_inc()         : sequential next word address, wrapping at 30 bits
package ifetch_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C0D;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_IDLE = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- small synchronous FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (drops all entries)
//   push, din  : write request and data (accepted when not full, or when full
//                and a pop happens in the same cycle)
//   pop        : read request (ignored when empty)
//   dout       : head entry (valid when count != 0)
//   count      : number of stored entries
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok_s  = pop && (cnt_r != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok_s = push && ((cnt_r != CNT_W'(DEPTH)) || pop_ok_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      cnt_r <= cnt_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = cnt_r;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch front end.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   redirect_valid/redirect_pc       : flush and restart from a resolved target
//   pred_valid/pred_pc               : flush and restart from a predicted target
//   fetch_en                         : allows new memory requests
//   imem_req/imem_addr/imem_gnt      : request channel to instruction memory
//   imem_rvalid/imem_rdata           : in-order response channel
//   id_valid/id_instr/id_pc/id_ready : instruction handoff to decode
//   fetch_pc                         : next word address to be requested
module ifetch_unit import ifetch_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               pred_valid,
  input  logic [PC_W-1:0]    pred_pc,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               id_ready,
  output logic [PC_W-1:0]    fetch_pc
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int FQ_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = $clog2(MAX_OUTST + FIFO_DEPTH + 1);
  localparam int ENT_W = INSTR_W + PC_W;

  fetch_state_e         state_r;
  fetch_state_e         state_s;
  logic [PC_W-1:0]      fetch_pc_r;
  logic [OUT_W-1:0]     outst_r;
  logic [OUT_W-1:0]     discard_r;
  logic                 flush_s;
  logic [PC_W-1:0]      flush_pc_s;
  logic                 req_s;
  logic                 gnt_s;
  logic                 rsp_s;
  logic                 keep_s;
  logic                 pop_s;
  logic [CR_W-1:0]      credit_s;
  logic [FQ_W-1:0]      ifq_cnt_s;
  logic [ENT_W-1:0]     ifq_dout_s;
  logic [OUT_W-1:0]     tag_cnt_s;
  logic [PC_W-1:0]      tag_head_s;

  // Redirects are ignored during the single BOOT cycle; the resolved redirect beats the prediction.
  assign flush_s    = (state_r != ST_BOOT) && (redirect_valid || pred_valid);
  assign flush_pc_s = redirect_valid ? redirect_pc : pred_pc;

  // Requests in flight plus buffered instructions must fit in the instruction queue.
  assign credit_s = CR_W'(outst_r) + CR_W'(ifq_cnt_s);
  assign req_s    = (state_r == ST_RUN) && fetch_en &&
                    (outst_r < OUT_W'(MAX_OUTST)) &&
                    (credit_s < CR_W'(FIFO_DEPTH)) &&
                    !redirect_valid && !pred_valid;
  assign gnt_s    = req_s && imem_gnt;
  assign rsp_s    = imem_rvalid && (outst_r != '0);
  // Only responses belonging to the current stream (tag present, nothing left to discard) are kept.
  assign keep_s   = rsp_s && (discard_r == '0) && !flush_s && (tag_cnt_s != '0);
  assign pop_s    = id_valid && id_ready;

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: state_s = ST_RUN;
      ST_RUN: begin
        if (!fetch_en && (outst_r == '0)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_IDLE: begin
        if (fetch_en) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_BOOT;
    endcase
  end

  // FSM state, fetch address, outstanding and discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_BOOT;
      fetch_pc_r <= RESET_PC;
      outst_r    <= '0;
      discard_r  <= '0;
    end else begin
      state_r <= state_s;
      if (flush_s) begin
        fetch_pc_r <= flush_pc_s;
      end else if (gnt_s) begin
        fetch_pc_r <= pc_inc(fetch_pc_r);
      end
      case ({gnt_s, rsp_s})
        2'b10:   outst_r <= outst_r + OUT_W'(1);
        2'b01:   outst_r <= outst_r - OUT_W'(1);
        default: outst_r <= outst_r;
      endcase
      // Every request still in flight after a flush returns stale data.
      if (flush_s) begin
        discard_r <= outst_r - OUT_W'(rsp_s);
      end else if (rsp_s && (discard_r != '0)) begin
        discard_r <= discard_r - OUT_W'(1);
      end
    end
  end

  ifetch_fifo #(
    .DEPTH(MAX_OUTST),
    .WIDTH(PC_W)
  ) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_s),
    .push  (gnt_s),
    .din   (fetch_pc_r),
    .pop   (keep_s),
    .dout  (tag_head_s),
    .count (tag_cnt_s)
  );

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENT_W)
  ) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_s),
    .push  (keep_s),
    .din   ({imem_rdata, tag_head_s}),
    .pop   (pop_s),
    .dout  (ifq_dout_s),
    .count (ifq_cnt_s)
  );

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;
  assign fetch_pc  = fetch_pc_r;
  assign id_valid  = (ifq_cnt_s != '0);
  assign id_instr  = id_valid ? ifq_dout_s[ENT_W-1 -: INSTR_W] : '0;
  assign id_pc     = id_valid ? ifq_dout_s[PC_W-1:0] : '0;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 30'h00000C0D, word address of first fetch (byte 0x00003034).
REQ-002 Parameter FIFO_DEPTH, default 2, instruction queue entries.
REQ-003 Parameter MAX_OUTST, default 2, maximum outstanding memory requests.
REQ-004 clk  in  1  sole clock, all state on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 redirect_valid  in  1  resolved-branch/jump/eret/syscall redirect from npc (flush).
REQ-007 redirect_pc  in  30  word address to fetch after redirect.
REQ-008 pred_valid  in  1  ID-stage predicted-branch redirect.
REQ-009 pred_pc  in  30  predicted word address.
REQ-010 fetch_en  in  1  when 0, no new requests issued.
REQ-011 imem_req  out  1  fetch request valid.
REQ-012 imem_addr  out  30  fetch word address.
REQ-013 imem_gnt  in  1  request accepted this cycle.
REQ-014 imem_rvalid  in  1  read data valid, in request order.
REQ-015 imem_rdata  in  32  instruction word.
REQ-016 id_valid  out  1  instruction available to ID.
REQ-017 id_instr  out  32  instruction word.
REQ-018 id_pc  out  30  word address of id_instr.
REQ-019 id_ready  in  1  ID accepts (deasserted on Hazard).
REQ-020 fetch_pc  out  30  next address to request (predictor lookup).

Function
REQ-021 FSM states BOOT, RUN, IDLE; BOOT lasts one cycle after rst_n release then RUN.
REQ-022 RUN->IDLE when fetch_en=0 and no outstanding requests; IDLE->RUN when fetch_en=1; redirect accepted in any state except BOOT.
REQ-023 imem_req asserted in RUN when fetch_en=1, outstanding<MAX_OUTST, outstanding+fifo_count<FIFO_DEPTH, and no redirect/pred this cycle.
REQ-024 imem_addr equals fetch_pc; held stable while imem_req=1 and imem_gnt=0.
REQ-025 imem_req&&imem_gnt: fetch_pc increments by 1 (30-bit wrap), outstanding +1, request PC pushed to a PC-tag queue.
REQ-026 imem_rvalid with discard_cnt=0: {rdata, tag PC} written into FIFO; id_valid earliest next cycle (1-cycle registered latency).
REQ-027 imem_rvalid with discard_cnt>0: response dropped, discard_cnt -1.
REQ-028 Pop when id_valid&&id_ready; push and pop same cycle allowed at any occupancy.
REQ-029 redirect_valid: fetch_pc<=redirect_pc, FIFO and tag queue cleared, discard_cnt<=outstanding minus any response consumed this cycle, id_valid 0 next cycle.
REQ-030 pred_valid alone: same action as REQ-029 using pred_pc; redirect_valid wins when both asserted.
REQ-031 Response coincident with redirect: dropped, counted out of discard total.
REQ-032 Withdrawing an ungranted imem_req is permitted only in a redirect cycle.
REQ-033 outstanding never exceeds MAX_OUTST; FIFO never overflows (guaranteed by REQ-023 credit rule).

Reset
REQ-034 rst_n low: fetch_pc=RESET_PC, state BOOT, FIFO/tag queue empty, outstanding=0, discard_cnt=0.
REQ-035 During reset imem_req=0, id_valid=0, id_instr=0, id_pc=0.
REQ-036 rst_n asserted mid-transaction: all in-flight responses forgotten; memory returns nothing after reset by system contract.

Structure
REQ-037 Shared package holds RESET_PC, PC width 30, instruction width 32, FSM state enum.
REQ-038 One sub-module ifetch_fifo (parameterised depth, sync, count output) used for both instruction and tag queues.

Verification
REQ-039 Reset release, gnt=1, rvalid 1 cycle later -> first imem_addr 0x0C0D, id_pc sequence 0x0C0D,0x0C0E,0x0C0F.
REQ-040 id_ready=0 for 5 cycles -> at most 2 requests outstanding/buffered, imem_req drops, no instruction lost or duplicated.
REQ-041 redirect_valid with 2 outstanding, redirect_pc=0x100 -> both old responses dropped, next id_pc=0x100.
REQ-042 redirect_valid and pred_valid same cycle (0x200 vs 0x300) -> fetch resumes at 0x200.
REQ-043 imem_gnt held 0 for 4 cycles -> imem_addr constant, fetch_pc unchanged until grant.
REQ-044 rst_n pulsed low with 2 outstanding -> outputs reset values immediately, fetch restarts at 0x0C0D.
